// File: rtl/prod_pkg.sv
// Shared types and sizing for the product-RAM readout sequencer.
// Optional build macro used by the consumers of this package: PROD_PEAK_TRACK_EN.
package prod_pkg;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int DATA_W = 16;
  // Width chosen so DEPTH full-scale products can never overflow.
  localparam int ACC_W  = DATA_W + ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    SEND,
    DONE
  } prod_state_t;

endpackage

// File: rtl/prod_readout_seq.sv
// Product-RAM readout sequencer: scans every product address once per start,
// streams each word over valid/ready and reports the accumulated dot product.
// Optional build macro: PROD_PEAK_TRACK_EN adds peak_out/peak_addr tracking.
module prod_readout_seq
  import prod_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [ACC_W-1:0]  sum_out,
  output logic              sum_valid,
`ifdef PROD_PEAK_TRACK_EN
  output logic [DATA_W-1:0] peak_out,
  output logic [ADDR_W-1:0] peak_addr,
`endif
  output logic              done
);

  prod_state_t       state;
  logic [ADDR_W-1:0] addr;
  logic [ACC_W-1:0]  acc;
  logic [DATA_W-1:0] data_reg;
  logic              last_addr;
  logic              handshake;

  assign last_addr = (addr == ADDR_W'(DEPTH - 1));
  assign handshake = (state == SEND) && out_ready;

  // Sequencer FSM, address counter, accumulator and output word register.
  // NOTE: every register here uses <= so all updates in a cycle see the
  // pre-edge values (e.g. acc and data_reg both consume this cycle's ram_data).
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      addr     <= '0;
      acc      <= '0;
      data_reg <= '0;
      sum_out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr  <= '0;
            acc   <= '0;
            state <= RD;
          end
        end
        RD:   state <= CAP;
        CAP: begin
          data_reg <= ram_data;
          acc      <= acc + ACC_W'(ram_data);
          state    <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            if (last_addr) begin
              // Latch the total on the final handshake so sum_out already
              // carries the new value during the DONE/sum_valid pulse.
              sum_out <= acc;
              state   <= DONE;
            end else begin
              addr  <= addr + 1'b1;
              state <= RD;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PROD_PEAK_TRACK_EN
  logic [DATA_W-1:0] peak_run;
  logic [ADDR_W-1:0] peak_addr_run;

  // Running maximum over the scan; strict compare keeps the earliest address on ties.
  always_ff @(posedge clk) begin
    if (reset) begin
      peak_run      <= '0;
      peak_addr_run <= '0;
      peak_out      <= '0;
      peak_addr     <= '0;
    end else if ((state == IDLE) && start) begin
      peak_run      <= '0;
      peak_addr_run <= '0;
      peak_out      <= '0;
      peak_addr     <= '0;
    end else if ((state == CAP) && (ram_data > peak_run)) begin
      peak_run      <= ram_data;
      peak_addr_run <= addr;
    end else if (handshake && last_addr) begin
      peak_out  <= peak_run;
      peak_addr <= peak_addr_run;
    end
  end
`endif

  // Outputs are decoded from state; ram_addr follows addr, which only moves
  // on entry to RD, so it holds its last value everywhere else.
  assign busy      = (state != IDLE);
  assign ram_rd_en = (state == RD);
  assign ram_addr  = addr;
  assign out_valid = (state == SEND);
  assign out_data  = data_reg;
  assign out_last  = (state == SEND) && last_addr;
  assign sum_valid = (state == DONE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_prod_readout_seq.sv
// Self-checking bench for prod_readout_seq: table of directed runs, random
// runs against a behavioural model, and hand-written reset-abort sequence.
// Optional build macro: PROD_PEAK_TRACK_EN enables peak output checks.
module tb_prod_readout_seq;
  import prod_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              busy;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data = '0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [ACC_W-1:0]  sum_out;
  logic              sum_valid;
  logic              done;
`ifdef PROD_PEAK_TRACK_EN
  logic [DATA_W-1:0] peak_out;
  logic [ADDR_W-1:0] peak_addr;
`endif

  prod_readout_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .ram_rd_en (ram_rd_en),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .sum_out   (sum_out),
    .sum_valid (sum_valid),
`ifdef PROD_PEAK_TRACK_EN
    .peak_out  (peak_out),
    .peak_addr (peak_addr),
`endif
    .done      (done)
  );

  always #5 clk = ~clk;

  // Product RAM model with one-cycle read latency.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) if (ram_rd_en) ram_data <= mem[ram_addr];

  int n_checks = 0;
  int n_fail   = 0;
  logic [ACC_W-1:0] exp_prev = '0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_ram_rd_en"}, ram_rd_en, 0);
    check({tag, "_ram_addr"},  ram_addr,  0);
    check({tag, "_out_data"},  out_data,  0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"},  out_last,  0);
    check({tag, "_sum_out"},   sum_out,   0);
    check({tag, "_sum_valid"}, sum_valid, 0);
    check({tag, "_done"},      done,      0);
  endtask

  // kind: 0 all ones, 1 all 0xFFFF, 2 addr*addr, 3 random, 4 peak pattern
  task automatic fill_mem(input int kind);
    for (int i = 0; i < DEPTH; i++) begin
      case (kind)
        0:       mem[i] = 16'd1;
        1:       mem[i] = 16'hFFFF;
        2:       mem[i] = DATA_W'(i * i);
        4:       mem[i] = DATA_W'($urandom_range(0, 16'h7FFF));
        default: mem[i] = DATA_W'($urandom);
      endcase
    end
    if (kind == 4) begin
      mem[3] = 16'h8000;
      mem[9] = 16'h8000;
    end
  endtask

  // mode: 0 always ready, 1 ready on odd cycles, 2 random
  function automatic logic rdy(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 2) == 1;
      default: return $urandom_range(0, 1) == 1;
    endcase
  endfunction

  // One complete scan, observed at negedges; cycle 0 is the start cycle.
  task automatic run_scan(input int mode, input bit restart, input bit has_exp,
                          input logic [ACC_W-1:0] exp_sum);
    logic [DATA_W-1:0] q[$];
    logic [ACC_W-1:0]  model_sum = '0;
    logic [DATA_W-1:0] pk = '0;
    int                pka = 0;
    int rd_cnt = 0, done_cnt = 0, done_cyc = -1, first_rd = -1, first_valid = -1;
    int last_cnt = 0, last_pos = -1;
    bit stalled = 0, finished = 0;
    logic [DATA_W-1:0] held_data = '0;
    logic              held_last = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      model_sum += ACC_W'(mem[i]);
      if (mem[i] > pk) begin
        pk  = mem[i];
        pka = i;
      end
    end
    if (has_exp) model_sum = exp_sum;

    @(negedge clk);
    start     = 1'b1;
    out_ready = rdy(mode, 0);
    for (int cyc = 1; cyc < 400 && !finished; cyc++) begin
      @(negedge clk);
      start     = restart && (cyc == 5 || cyc == 20);
      out_ready = rdy(mode, cyc);
      if (cyc == 1) check("sum_hold_on_start", sum_out, exp_prev);
      if (ram_rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (stalled) begin
        check("stall_valid", out_valid, 1);
        check("stall_data",  out_data,  held_data);
        check("stall_last",  out_last,  held_last);
      end
      if (out_valid && out_ready) begin
        q.push_back(out_data);
        if (out_last) begin
          last_cnt++;
          last_pos = q.size();
        end
        stalled = 0;
      end else if (out_valid) begin
        stalled   = 1;
        held_data = out_data;
        held_last = out_last;
      end else begin
        stalled = 0;
      end
      if (sum_valid !== done) check("sum_valid_eq_done", sum_valid, done);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("sum_out", sum_out, model_sum);
`ifdef PROD_PEAK_TRACK_EN
        check("peak_out",  peak_out,  pk);
        check("peak_addr", peak_addr, pka);
`endif
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        check("busy_after_done", busy, 0);
        finished = 1;
      end
    end
    start     = 1'b0;
    out_ready = 1'b0;
    if (!finished) check("scan_timeout", 0, 1);
    check("word_count", q.size(), DEPTH);
    for (int i = 0; i < q.size() && i < DEPTH; i++) check("word_order", q[i], mem[i]);
    check("last_count", last_cnt, 1);
    check("last_pos",   last_pos, DEPTH);
    check("done_count", done_cnt, 1);
    check("rd_count",   rd_cnt,   DEPTH);
    if (mode == 0) begin
      check("first_rd_cycle",    first_rd,    1);
      check("first_valid_cycle", first_valid, 3);
      check("done_cycle",        done_cyc,    49);
    end
    exp_prev = model_sum;
  endtask

  typedef struct {
    int               fill;
    int               mode;
    bit               restart;
    bit               has_exp;
    logic [ACC_W-1:0] exp_sum;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{fill: 0, mode: 0, restart: 0, has_exp: 1, exp_sum: 20'd16};
    vecs[1] = '{fill: 1, mode: 0, restart: 0, has_exp: 1, exp_sum: 20'd1048560};
    vecs[2] = '{fill: 2, mode: 1, restart: 0, has_exp: 1, exp_sum: 20'd1240};
    vecs[3] = '{fill: 0, mode: 0, restart: 1, has_exp: 1, exp_sum: 20'd16};
    vecs[4] = '{fill: 3, mode: 2, restart: 0, has_exp: 0, exp_sum: '0};
    vecs[5] = '{fill: 3, mode: 2, restart: 1, has_exp: 0, exp_sum: '0};
    vecs[6] = '{fill: 3, mode: 0, restart: 0, has_exp: 0, exp_sum: '0};
    vecs[7] = '{fill: 4, mode: 0, restart: 0, has_exp: 0, exp_sum: '0};

    reset     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    fill_mem(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b0;

    for (int v = 0; v < 8; v++) begin
      fill_mem(vecs[v].fill);
      run_scan(vecs[v].mode, vecs[v].restart, vecs[v].has_exp, vecs[v].exp_sum);
`ifdef PROD_PEAK_TRACK_EN
      if (vecs[v].fill == 4) begin
        check("peak_pattern_value", peak_out,  16'h8000);
        check("peak_pattern_addr",  peak_addr, 3);
      end
`endif
    end

    // Reset asserted at cycle 10 of a run aborts it with no sum reported.
    fill_mem(3);
    @(negedge clk);
    start     = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 10) reset = 1'b1;
    end
    @(negedge clk);
    check_idle_zero("abort");
    reset    = 1'b0;
    exp_prev = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_sum_valid", sum_valid, 0);
      check("abort_idle",         busy,      0);
    end
    out_ready = 1'b0;
    run_scan(0, 0, 0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prod_readout_seq.md
Name: prod_readout_seq

Overview:
- Downstream consumer of the 16x16 product RAM in the dual-RAM multiply datapath.
- On start, scans all product addresses in order and reads each 16-bit product (1-cycle read latency).
- Streams each product out over a valid/ready handshake and accumulates a running sum.
- Presents the final dot-product sum with a one-cycle done/sum_valid pulse.

Parameters:
- DEPTH, 16, number of product words scanned per run.
- ADDR_W, 4, RAM address width; $clog2(DEPTH).
- DATA_W, 16, product word width.
- ACC_W, 20, accumulator width (DATA_W+ADDR_W); sum can never overflow.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin scan; sampled only in IDLE.
- busy  out  1  high in any state other than IDLE.
- ram_rd_en  out  1  read strobe to product RAM (drives its op_en).
- ram_addr  out  ADDR_W  read address to product RAM.
- ram_data  in  DATA_W  RAM read data, valid the cycle after ram_rd_en.
- out_data  out  DATA_W  streamed product.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts when out_valid && out_ready.
- out_last  out  1  high with the final word (addr DEPTH-1).
- sum_out  out  ACC_W  accumulated sum of the last completed run.
- sum_valid  out  1  one-cycle pulse when sum_out updates.
- done  out  1  one-cycle pulse at scan completion (same cycle as sum_valid).

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset: state=IDLE. All outputs 0: busy, ram_rd_en, ram_addr, out_data, out_valid, out_last, sum_out, sum_valid, done. Internal addr and acc are also cleared.
- Reset mid-scan aborts immediately. No partial sum is reported.
- IDLE: if start=1, set addr=0 and acc=0, then go to RD. Otherwise stay in IDLE.
- RD: assert ram_rd_en=1 with ram_addr=addr for exactly one cycle, then go to CAP.
- CAP: capture data_reg<=ram_data and update acc<=acc+ram_data (zero-extended to ACC_W), then go to SEND.
- SEND: drive out_valid=1, out_data=data_reg, out_last=(addr==DEPTH-1).
  - out_data and out_last are held stable while out_ready=0.
  - On a handshake with out_last=1, go to DONE.
  - On any other handshake, addr++ and go to RD.
- DONE: latch sum_out<=acc, pulse sum_valid=1 and done=1 for one cycle, then go to IDLE.
- sum_out holds its value until the next DONE or reset. It is not cleared by start.
- start is ignored while busy=1. start in the DONE cycle is ignored; start is honoured from the next IDLE cycle.
- ram_rd_en is 0 outside RD. ram_addr holds its last value outside RD.
- Latency with out_ready tied to 1:
  - Start accepted at cycle 0; first ram_rd_en at cycle 1; first out_valid at cycle 3.
  - Each word takes 3 cycles; the last handshake falls at cycle 48.
  - done/sum_valid pulse at cycle 49; busy returns to 0 at cycle 50.
- Back-pressure adds one cycle per cycle of out_ready=0. The RAM is never re-read for a stalled word.
- No address wrap: the scan stops at DEPTH-1.

Optional Feature:
- Macro: PROD_PEAK_TRACK_EN.
- Defined: adds outputs peak_out[DATA_W-1:0] and peak_addr[ADDR_W-1:0].
  - Both are cleared on start accept. On each CAP, they update if ram_data > peak (strict, so the earliest address wins ties).
  - Both are latched to their final values in DONE. They reset to 0.
- Undefined: the ports and logic are absent. All other behaviour is identical.

Decomposition:
- Shared package prod_pkg holds:
  - typedef enum logic [2:0] {IDLE, RD, CAP, SEND, DONE} prod_state_t;
  - localparams DEPTH, ADDR_W, DATA_W, ACC_W.
- No sub-module is needed: the FSM, address counter, accumulator and output register live in one module.

Test Plan:
- RAM model preloaded with 1 at all 16 addresses, out_ready=1, start pulse -> 16 out_valid words of 1, out_last on the 16th only, sum_out=16, done at cycle 49.
- All entries 0xFFFF -> sum_out=0xFFFF0 (1048560), no overflow.
- Entries addr*addr (0..225), out_ready toggled every other cycle -> word order 0,1,4,...,225 with none dropped or duplicated, out_data stable while stalled, sum_out=1240.
- start re-pulsed at cycles 5 and 20 of a run -> ignored, exactly 16 words, a single done.
- reset asserted at cycle 10 of a run -> next cycle all outputs 0 and busy=0; a new start gives a full correct run, and sum_valid fires only for that run.
- PROD_PEAK_TRACK_EN, entries with 0x8000 at addr 3 and addr 9, others smaller -> peak_out=0x8000, peak_addr=3.
